// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer: display modes,
// their initial patterns and the mode advance order.
package led_seq_pkg;

    localparam int unsigned LED_W = 8;

    typedef enum logic [1:0] {
        BINARY = 2'd0,
        CHASE  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    localparam logic [LED_W-1:0] INIT_BINARY = 8'h00;
    localparam logic [LED_W-1:0] INIT_CHASE  = 8'h01;
    localparam logic [LED_W-1:0] INIT_BOUNCE = 8'h01;
    localparam logic [LED_W-1:0] INIT_BLINK  = 8'hFF;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            BINARY:  return CHASE;
            CHASE:   return BOUNCE;
            BOUNCE:  return BLINK;
            default: return BINARY;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
        case (m)
            BINARY:  return INIT_BINARY;
            CHASE:   return INIT_CHASE;
            BOUNCE:  return INIT_BOUNCE;
            default: return INIT_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Board-facing signal bundle: button and run enable in, LED bank and status out.
interface led_seq_if;
    import led_seq_pkg::*;

    logic             btn;
    logic             en;
    logic [LED_W-1:0] led;
    mode_t            mode;
    logic             tick;

    modport master (output btn, output en, input led, input mode, input tick);
    modport slave  (input btn, input en, output led, output mode, output tick);

endinterface

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stability counter and a
// registered one-cycle pulse on each debounced press (rising level only).
module btn_debounce #(
    parameter int unsigned DB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    logic               sync1;
    logic               sync2;
    logic               stable;
    logic [DB_BITS-1:0] cnt;

    // The stable level flips on the 2^DB_BITS-th consecutive differing cycle;
    // the pulse is registered on that same edge so press latency is fixed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == {DB_BITS{1'b1}}) begin
                    stable <= sync2;
                    cnt    <= '0;
                    pulse  <= sync2;
                end else begin
                    cnt <= cnt + DB_BITS'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Pattern engine for the 8-LED bank: prescaled step rate, button-driven mode
// FSM and per-mode pattern generation. Sole owner of the LED outputs.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_BITS = 22,
    parameter int unsigned DB_BITS   = 16
) (
    input  logic      clk,
    input  logic      rst,
    led_seq_if.slave  bus
);

    logic                 btn_pulse;
    mode_t                mode_q;
    mode_t                mode_d;
    logic [LED_W-1:0]     led_q;
    logic [LED_W-1:0]     led_d;
    logic [TICK_BITS-1:0] presc_q;
    logic [TICK_BITS-1:0] presc_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 dir_up_q;
    logic                 dir_up_d;

    btn_debounce #(.DB_BITS(DB_BITS)) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn),
        .pulse   (btn_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= BINARY;
            led_q    <= INIT_BINARY;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            dir_up_q <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            dir_up_q <= dir_up_d;
        end
    end

    // Next-state: prescaler, pattern step on tick, then a button press
    // overrides everything (a pending step is dropped in favour of the new mode).
    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        dir_up_d = dir_up_q;

        if (bus.en) begin
            presc_d = presc_q + TICK_BITS'(1);
            tick_d  = (presc_q == {TICK_BITS{1'b1}});
        end

        if (tick_q) begin
            case (mode_q)
                BINARY: led_d = led_q + 8'd1;
                CHASE:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                BOUNCE: begin
                    if (dir_up_q) begin
                        if (led_q[LED_W-1]) begin
                            led_d    = 8'h40;
                            dir_up_d = 1'b0;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d    = 8'h02;
                            dir_up_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default: led_d = ~led_q;
            endcase
        end

        if (btn_pulse) begin
            mode_d   = next_mode(mode_q);
            led_d    = init_pattern(mode_d);
            presc_d  = '0;
            tick_d   = 1'b0;
            dir_up_d = 1'b1;
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick_q;

endmodule
